uart_tx_mmio: RTL and testbench
===============================

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter BUS_WIDTH, default 32: data bus and address width.
REQ-002 Parameter FIFO_DEPTH, default 8, power of two: depth of the transmit byte FIFO.
REQ-003 Parameter DEF_BAUD_DIV, default 868: reset value of the baud divisor (clocks per bit).
REQ-004 clk  input  1: the single clock; all logic is rising-edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 sel  input  1: peripheral selected by the core's memory stage this cycle.
REQ-007 we  input  1: store strobe; qualified by sel.
REQ-008 re  input  1: load strobe; qualified by sel.
REQ-009 addr  input  BUS_WIDTH: byte address; only addr[3:2] are decoded.
REQ-010 wdata  input  BUS_WIDTH: store data.
REQ-011 rdata  output  BUS_WIDTH: registered load data, feeding the writeback load path.
REQ-012 tx  output  1: serial line; idle high.
REQ-013 irq  output  1: high while the FIFO is empty and the transmitter is idle.

Function
REQ-014 The register map SHALL be: addr[3:2]=0 TXDATA (W), 1 STATUS (R), 2 BAUDDIV (R/W, 16 bits), 3 reserved (reads 0, writes ignored).
REQ-015 A store to TXDATA (sel&we) SHALL push wdata[7:0] into the FIFO at the next edge when not full.
REQ-016 A store to TXDATA while the FIFO is full SHALL drop the byte and set the sticky flag ovf.
REQ-017 STATUS SHALL read {zero-pad, count[log2(FIFO_DEPTH):0] at bits[15:8], ovf bit3, busy bit2, empty bit1, full bit0}.
REQ-018 A load (sel&re) SHALL update rdata at the next edge with the addressed register value sampled in the request cycle; one-cycle latency.
REQ-019 rdata SHALL hold its previous value in cycles without sel&re.
REQ-020 A load of STATUS SHALL clear ovf at the same edge that rdata captures it; an overflowing store in that same cycle SHALL leave ovf set.
REQ-021 A store to BAUDDIV SHALL write wdata[15:0]; the value 0 or 1 SHALL be stored as 2.
REQ-022 The TX FSM SHALL have states IDLE, START, DATA, STOP.
REQ-023 In IDLE, with the FIFO non-empty, the FSM SHALL pop one byte, latch it and the current BAUDDIV, and enter START at the next edge.
REQ-024 START SHALL drive tx=0 for exactly div clocks, then enter DATA.
REQ-025 DATA SHALL drive the 8 bits LSB first, each for div clocks, then enter STOP.
REQ-026 STOP SHALL drive tx=1 for div clocks, then return to IDLE.
REQ-027 A frame SHALL therefore be 10*div clocks.
REQ-028 The next frame SHALL start with no extra idle bit when the FIFO is non-empty at STOP exit: IDLE lasts one clock.
REQ-029 busy SHALL be 1 in every state other than IDLE.
REQ-030 A BAUDDIV write mid-frame SHALL take effect from the next frame only.
REQ-031 A push and a pop in the same cycle SHALL both occur, leaving count unchanged.
REQ-032 A push to an empty FIFO while IDLE SHALL NOT be popped in that same cycle; the pop occurs the cycle after.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 count SHALL saturate at neither bound, because full and empty guard it.
REQ-035 Simultaneous sel&we and sel&re SHALL perform both the write and the read; a read of BAUDDIV in that case returns the old value.

Reset
REQ-036 rst SHALL, at the next edge, set: FSM to IDLE, tx=1, FIFO empty (pointers and count 0), ovf=0, BAUDDIV=DEF_BAUD_DIV, rdata=0, irq=1.
REQ-037 rst asserted mid-frame SHALL abort the frame, with tx high from the following clock.
REQ-038 rst SHALL take priority over any concurrent bus access.

Verification
REQ-039 DEF_BAUD_DIV=4; store 0x55 to TXDATA -> tx low for clocks 2-5 after the store, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high for 4 clocks; busy high for 40 clocks; irq returns to 1.
REQ-040 Store 9 bytes back-to-back while the first frame is in flight (depth 8) -> 9th byte dropped; STATUS reads full=1, ovf=1, count=8; a second STATUS read returns ovf=0.
REQ-041 Load STATUS issued in cycle N -> rdata valid at edge N+1; with no further sel&re, rdata stays constant for 5 further cycles.
REQ-042 Write BAUDDIV=8 in the middle of the frame for 0xA3 with a 0x3C queued -> 0xA3 keeps 4-clock bits; 0x3C uses 8-clock bits, begins immediately after the stop bit, and occupies 80 clocks.
REQ-043 Assert rst during bit 3 of a frame -> tx=1, busy=0, count=0, BAUDDIV=4 on the next clock; a subsequent store 0xFF transmits normally.
REQ-044 Write BAUDDIV=0 -> reads back 2; a frame then occupies 20 clocks.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with a byte FIFO, a programmable baud divisor and an idle interrupt.
module uart_tx_mmio #(
  parameter int BUS_WIDTH    = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int DEF_BAUD_DIV = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic                 we,
  input  logic                 re,
  input  logic [BUS_WIDTH-1:0] addr,
  input  logic [BUS_WIDTH-1:0] wdata,
  output logic [BUS_WIDTH-1:0] rdata,
  output logic                 tx,
  output logic                 irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic [15:0] div_q, div_d, fdiv_q, fdiv_d, cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] bit_q, bit_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d, status;
  logic wr, rd, full, empty, busy, push, pop, tick;
  logic unused;
  assign unused = ^{addr[BUS_WIDTH-1:4], addr[1:0], wdata[BUS_WIDTH-1:16]};
  assign wr = sel & we;
  assign rd = sel & re;
  assign full = count_q == (AW+1)'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign busy = state_q != IDLE;
  assign push = wr && addr[3:2] == 2'd0 && !full;
  // count is registered, so a byte pushed this cycle cannot be popped until the next one
  assign pop = state_q == IDLE && !empty;
  assign tick = cnt_q == '0;
  assign tx = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : 1'b1;
  assign irq = empty & ~busy;
  assign rdata = rdata_q;
  always_comb begin
    status = '0;
    status[8 +: AW+1] = count_q;
    status[3:0] = {ovf_q, busy, empty, full};
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d = (ovf_q & ~(rd && addr[3:2] == 2'd1)) | (wr && addr[3:2] == 2'd0 && full);
    div_d = wr && addr[3:2] == 2'd2 ? (wdata[15:1] == 15'd0 ? 16'd2 : wdata[15:0]) : div_q;
    rdata_d = !rd ? rdata_q : addr[3:2] == 2'd1 ? status : addr[3:2] == 2'd2 ? BUS_WIDTH'(div_q) : '0;
    state_d = state_q;
    fdiv_d = fdiv_q;
    cnt_d = tick ? fdiv_q - 16'd1 : cnt_q - 16'd1;
    sh_d = sh_q;
    bit_d = bit_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d = START;
        sh_d = mem_q[rd_ptr_q];
        fdiv_d = div_q;
        cnt_d = div_q - 16'd1;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (tick) begin
        sh_d = sh_q >> 1;
        bit_d = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      div_q <= 16'(DEF_BAUD_DIV);
      fdiv_q <= '0;
      cnt_q <= '0;
      sh_q <= '0;
      bit_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      div_q <= div_d;
      fdiv_q <= fdiv_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= wdata[7:0];
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed bench for uart_tx_mmio with a 4-clock default divisor.
module tb_uart_tx_mmio;
  logic clk, rst, sel, we, re, tx, irq;
  logic [31:0] addr, wdata, rdata;
  int total = 0;
  int bad = 0;
  logic [7:0] tbl [9] = '{8'h01, 8'h80, 8'hC3, 8'h5A, 8'hFF, 8'h00, 8'h7E, 8'h96, 8'hEE};

  uart_tx_mmio #(.BUS_WIDTH(32), .FIFO_DEPTH(8), .DEF_BAUD_DIV(4)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .tx(tx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    step();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a);
    sel = 1'b1; re = 1'b1; addr = a;
    step();
    sel = 1'b0; re = 1'b0;
  endtask

  // Checks frame offsets k0..k1-1 (offset 0 = first START clock), one clock per offset.
  task automatic check_frame(input logic [7:0] b, input int div, input int k0, input int k1, input string tag);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = k0; k < k1; k++) begin
      chk({tag, "_tx"}, {31'b0, tx}, {31'b0, f[k/div]});
      chk({tag, "_irq"}, {31'b0, irq}, 32'd0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_irq", {31'b0, irq}, 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    rd_reg(32'h4);
    chk("rst_status", rdata, 32'h0000_0002);
    rd_reg(32'h8);
    chk("rst_div", rdata, 32'd4);

    wr_reg(32'h0, 32'h55);
    chk("t1_pre_tx", {31'b0, tx}, 32'd1);
    chk("t1_pre_irq", {31'b0, irq}, 32'd0);
    step();
    check_frame(8'h55, 4, 0, 40, "t1");
    chk("t1_end_irq", {31'b0, irq}, 32'd1);
    chk("t1_end_tx", {31'b0, tx}, 32'd1);

    wr_reg(32'h0, 32'h11);
    step();
    for (int i = 0; i < 9; i++) begin
      sel = 1'b1; we = 1'b1; addr = 32'h0; wdata = {24'h0, tbl[i]};
      step();
    end
    sel = 1'b0; we = 1'b0;
    rd_reg(32'h4);
    chk("t2_status_full", rdata, 32'h0000_080D);
    rd_reg(32'h4);
    chk("t2_status_clr", rdata, 32'h0000_0805);
    check_frame(8'h11, 4, 11, 40, "t2_first");
    for (int i = 0; i < 8; i++) begin
      step();
      check_frame(tbl[i], 4, 0, 40, "t2_drain");
    end
    chk("t2_end_irq", {31'b0, irq}, 32'd1);
    rd_reg(32'h4);
    chk("t2_end_status", rdata, 32'h0000_0002);

    rd_reg(32'h4);
    chk("t3_rd", rdata, 32'h0000_0002);
    wr_reg(32'h0, 32'hA3);
    chk("t3_hold1", rdata, 32'h0000_0002);
    wr_reg(32'h0, 32'h3C);
    chk("t3_hold2", rdata, 32'h0000_0002);
    check_frame(8'hA3, 4, 0, 5, "t3_a3");
    chk("t3_hold7", rdata, 32'h0000_0002);
    wr_reg(32'h8, 32'h8);
    check_frame(8'hA3, 4, 6, 40, "t3_a3");
    chk("t3_gap_tx", {31'b0, tx}, 32'd1);
    chk("t3_gap_irq", {31'b0, irq}, 32'd0);
    step();
    check_frame(8'h3C, 8, 0, 80, "t3_3c");
    chk("t3_end_irq", {31'b0, irq}, 32'd1);
    rd_reg(32'h8);
    chk("t3_div", rdata, 32'd8);

    sel = 1'b1; we = 1'b1; re = 1'b1; addr = 32'h8; wdata = 32'd16;
    step();
    sel = 1'b0; we = 1'b0; re = 1'b0;
    chk("t4_rw_old", rdata, 32'd8);
    rd_reg(32'h8);
    chk("t4_rw_new", rdata, 32'd16);
    rd_reg(32'hC);
    chk("t4_rsvd_rd", rdata, 32'd0);
    wr_reg(32'hC, 32'h3);
    rd_reg(32'h8);
    chk("t4_rsvd_wr", rdata, 32'd16);

    wr_reg(32'h8, 32'd6);
    wr_reg(32'h0, 32'h96);
    wr_reg(32'h0, 32'h5B);
    check_frame(8'h96, 6, 0, 26, "t5_96");
    rst = 1'b1; sel = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'h77;
    step();
    rst = 1'b0; sel = 1'b0; we = 1'b0;
    chk("t5_rst_tx", {31'b0, tx}, 32'd1);
    chk("t5_rst_irq", {31'b0, irq}, 32'd1);
    chk("t5_rst_rdata", rdata, 32'd0);
    rd_reg(32'h4);
    chk("t5_rst_status", rdata, 32'h0000_0002);
    rd_reg(32'h8);
    chk("t5_rst_div", rdata, 32'd4);
    wr_reg(32'h0, 32'hFF);
    step();
    check_frame(8'hFF, 4, 0, 40, "t5_ff");
    chk("t5_end_irq", {31'b0, irq}, 32'd1);

    wr_reg(32'h8, 32'd0);
    rd_reg(32'h8);
    chk("t6_div0", rdata, 32'd2);
    wr_reg(32'h0, 32'h3A);
    step();
    check_frame(8'h3A, 2, 0, 20, "t6_3a");
    chk("t6_end_irq", {31'b0, irq}, 32'd1);
    chk("t6_end_tx", {31'b0, tx}, 32'd1);
    wr_reg(32'h8, 32'd1);
    rd_reg(32'h8);
    chk("t6_div1", rdata, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
